tile_vec_loader: RTL
====================

TILE_VEC_LOADER -- requirements
Module: tile_vec_loader

Interface
REQ-001 Parameter TILE_SIZE, default 128, is the number of fp16 elements per operand vector.
REQ-002 Parameter DATA_WIDTH, default 16, is the element width in bits (fp16).
REQ-003 Parameter LANES, default 8, is the number of elements per input beat; TILE_SIZE SHALL be a multiple of LANES; BEATS = TILE_SIZE/LANES (16 by default).
REQ-004 Port clk_i, input, 1: the single clock.
REQ-005 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 Port flush_i, input, 1: synchronous abort of the current job.
REQ-007 Port cfg_valid_i, input, 1: job command valid.
REQ-008 Port cfg_ready_o, output, 1: job command accepted.
REQ-009 Port cfg_mode_i, input, 1: 1 = scalar job, 0 = vector job.
REQ-010 Port cfg_scal_i, input, DATA_WIDTH: scalar operand for scalar jobs.
REQ-011 Port in_valid_i, input, 1: data beat valid.
REQ-012 Port in_ready_o, output, 1: data beat accepted.
REQ-013 Port in_data_i, input, LANES x DATA_WIDTH: packed beat, lane 0 in the LSBs.
REQ-014 Port out_valid_o, output, 1: operand set ready for the multiply/adder-tree tile.
REQ-015 Port out_ready_i, input, 1: tile consumes the operand set.
REQ-016 Port vec1_o, output, TILE_SIZE x DATA_WIDTH: first operand vector.
REQ-017 Port vec2_o, output, TILE_SIZE x DATA_WIDTH: second operand vector.
REQ-018 Port scal_o, output, DATA_WIDTH: scalar operand.
REQ-019 Port control_o, output, 1: tile mode select (1 scalar, 0 vector).
REQ-020 Port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, FILL1, FILL2, PRESENT.
REQ-022 IDLE: cfg_ready_o = 1; on cfg_valid_i & cfg_ready_o, latch cfg_mode_i into control_o and cfg_scal_i into scal_o (scal_o latched only when cfg_mode_i = 1, else unchanged); go to FILL1 with beat counter 0.
REQ-023 FILL1/FILL2: in_ready_o = 1 (combinationally 0 when flush_i = 1); each accepted beat k writes lane l to element LANES*k+l of vec1 (FILL1) or vec2 (FILL2); beat counter increments.
REQ-024 Beat counter SHALL wrap BEATS-1 -> 0 on the last accepted beat of a fill; FILL1 then goes to FILL2 if control_o = 0, else PRESENT; FILL2 goes to PRESENT.
REQ-025 Cycles with in_valid_i = 0 in FILL states SHALL leave counter, buffers and state unchanged.
REQ-026 Scalar jobs SHALL NOT write vec2; vec2_o keeps its previous contents.
REQ-027 PRESENT: out_valid_o = 1; vec1_o, vec2_o, scal_o, control_o stable until out_ready_i = 1, then go to IDLE next cycle.
REQ-028 out_valid_o SHALL rise the cycle after the final beat is accepted (latency 1); minimum job duration is BEATS+2 cycles (scalar) or 2*BEATS+2 (vector), including the cfg cycle.
REQ-029 cfg_ready_o, in_ready_o and out_valid_o SHALL be mutually exclusive; cfg_ready_o depends only on state.
REQ-030 Data beats offered in IDLE or PRESENT SHALL NOT be accepted.
REQ-031 flush_i = 1 in any state SHALL return to IDLE next cycle, counter 0, no beat/cfg accepted that cycle; buffers keep contents; out_valid_o drops.
REQ-032 flush_i coinciding with out_ready_i in PRESENT: flush wins, result identical (IDLE).

Reset
REQ-033 On rst_ni = 0, asynchronously: state IDLE, beat counter 0, vec1_o, vec2_o, scal_o all zero, control_o 0, out_valid_o 0, in_ready_o 0, busy_o 0; cfg_ready_o 1 once reset released.
REQ-034 Reset mid-fill or mid-PRESENT SHALL discard the job; first cfg after release starts a fresh job.

Verification
REQ-035 Vector job: cfg mode 0; 32 beats, element i = i (vec1) and 0x3C00 (vec2) -> out_valid_o on cycle after beat 32, vec1_o[127] = 127, vec2_o all 0x3C00, control_o 0.
REQ-036 Scalar job: cfg mode 1, scal 0x4000; 16 beats -> PRESENT after beat 16, scal_o 0x4000, control_o 1, vec2_o unchanged from prior job.
REQ-037 Backpressure: in_valid_i toggled every other cycle and out_ready_i held 0 for 10 cycles -> no beat lost/duplicated, outputs stable throughout PRESENT.
REQ-038 Flush after beat 7 of FILL1 -> IDLE next cycle, busy_o 0; next full job loads correctly with counter from 0.
REQ-039 Async reset asserted mid-FILL2 (no clock edge) -> all outputs zero immediately; out_valid_o 0.
REQ-040 Protocol: beats offered in IDLE and PRESENT -> in_ready_o 0, buffers unchanged; flush with out_ready_i in PRESENT -> IDLE.

Source files
------------

// File: rtl/tile_vec_loader.sv
// -----------------------------------------------------------------------------
// tile_vec_loader
//
// Collects two fp16 operand vectors (or one vector plus a scalar) from a
// LANES-wide beat stream and presents them as one operand set to the
// multiply/adder-tree tile.
//
// Job flow: IDLE -> FILL1 -> (FILL2 for vector jobs) -> PRESENT -> IDLE.
// - A vector job fills vec1 and then vec2.
// - A scalar job fills vec1 only. vec2 keeps the contents of the last
//   vector job.
// - flush_i aborts any state back to IDLE and leaves the buffers untouched.
//
// Ports
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   flush_i      : synchronous abort of the current job
//   cfg_valid_i  : job command handshake (valid)
//   cfg_ready_o  : job command handshake (ready)
//   cfg_mode_i   : 1 = scalar job, 0 = vector job
//   cfg_scal_i   : scalar operand (captured only for scalar jobs)
//   in_valid_i   : data beat handshake (valid)
//   in_ready_o   : data beat handshake (ready)
//   in_data_i    : LANES elements, lane 0 in the LSBs
//   out_valid_o  : operand set handshake (valid)
//   out_ready_i  : operand set handshake (ready)
//   vec1_o       : first operand vector
//   vec2_o       : second operand vector
//   scal_o       : scalar operand
//   control_o    : tile mode select (1 scalar, 0 vector)
//   busy_o       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module tile_vec_loader #(
    parameter int TILE_SIZE  = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             cfg_valid_i,
    output logic                             cfg_ready_o,
    input  logic                             cfg_mode_i,
    input  logic [DATA_WIDTH-1:0]            cfg_scal_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0]      in_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [TILE_SIZE*DATA_WIDTH-1:0]  vec1_o,
    output logic [TILE_SIZE*DATA_WIDTH-1:0]  vec2_o,
    output logic [DATA_WIDTH-1:0]            scal_o,
    output logic                             control_o,
    output logic                             busy_o
);

    localparam int BEATS  = TILE_SIZE / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam int VEC_W  = TILE_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL1   = 2'd1,
        FILL2   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [CNT_W-1:0]       beat_cnt_nxt_s;
    logic                   last_beat_s;
    logic                   cfg_fire_s;
    logic                   beat_fire_s;
    logic [VEC_W-1:0]       vec1_r;
    logic [VEC_W-1:0]       vec2_r;
    logic [DATA_WIDTH-1:0]  scal_r;
    logic                   control_r;

    assign last_beat_s = (beat_cnt_r == CNT_W'(BEATS - 1));
    // cfg_ready_o is a pure state decode, so flush has to gate the accept here
    assign cfg_fire_s  = cfg_valid_i & cfg_ready_o & ~flush_i;
    // in_ready_o already drops under flush
    assign beat_fire_s = in_valid_i & in_ready_o;

    // State and beat counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Next-state, counter and handshake decode
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        cfg_ready_o    = 1'b0;
        in_ready_o     = 1'b0;
        out_valid_o    = 1'b0;
        busy_o         = 1'b1;
        case (state_r)
            IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i) begin
                    state_nxt_s    = FILL1;
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            FILL1, FILL2: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (last_beat_s) begin
                        beat_cnt_nxt_s = {CNT_W{1'b0}};
                        // a scalar job has no second vector to load
                        if (state_r == FILL1 && !control_r) begin
                            state_nxt_s = FILL2;
                        end else begin
                            state_nxt_s = PRESENT;
                        end
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            PRESENT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PRESENT;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                beat_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
        // flush overrides everything, including an out_ready_i in PRESENT
        if (flush_i) begin
            state_nxt_s    = IDLE;
            beat_cnt_nxt_s = {CNT_W{1'b0}};
            in_ready_o     = 1'b0;
        end else begin
            in_ready_o     = in_ready_o;
        end
    end

    // Job configuration capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            control_r <= 1'b0;
            scal_r    <= {DATA_WIDTH{1'b0}};
        end else if (cfg_fire_s) begin
            control_r <= cfg_mode_i;
            if (cfg_mode_i) begin
                scal_r <= cfg_scal_i;
            end else begin
                scal_r <= scal_r;
            end
        end else begin
            control_r <= control_r;
            scal_r    <= scal_r;
        end
    end

    // Operand buffers: beat k lands in elements LANES*k .. LANES*k+LANES-1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec1_r <= {VEC_W{1'b0}};
            vec2_r <= {VEC_W{1'b0}};
        end else if (beat_fire_s) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt_r == CNT_W'(b)) begin
                    if (state_r == FILL1) begin
                        vec1_r[b*BEAT_W +: BEAT_W] <= in_data_i;
                    end else begin
                        vec2_r[b*BEAT_W +: BEAT_W] <= in_data_i;
                    end
                end
            end
        end else begin
            vec1_r <= vec1_r;
            vec2_r <= vec2_r;
        end
    end

    assign vec1_o    = vec1_r;
    assign vec2_o    = vec2_r;
    assign scal_o    = scal_r;
    assign control_o = control_r;

endmodule
